control_unit_fsm: RTL
=====================

Name: control_unit_fsm

Overview:
- Fetch/decode/execute controller for the 8-bit accumulator processor.
- Sits directly upstream of the datapath and drives all of its control strobes: IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload and Sub.
- Consumes the datapath's status outputs: opcode IR75, Aeq0 and Apos.
- Sequences one instruction at a time against the datapath's synchronous-read memory. Memory data is valid one clock after its address is presented.

Parameters:
ASEL_ALU, 2'b00, Asel code selecting the adder/subtractor result into A
ASEL_IN, 2'b01, Asel code selecting the external input port into A
ASEL_MEM, 2'b10, Asel code selecting memory data into A

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
IR75  input  3  opcode field from the instruction register
Aeq0  input  1  accumulator == 0
Apos  input  1  accumulator > 0 (MSB clear and nonzero)
enter  input  1  operator input-valid, level, sampled in INPUT state
step  input  1  single-step advance; used only under CU_STEP_EN
IRload  output  1  load IR from memory data
JMPmux  output  1  0: PC+1, 1: IR40 into PC
PCload  output  1  load PC
Meminst  output  1  0: address = PC, 1: address = IR40
MemWr  output  1  write A to memory
Asel  output  2  A input mux select
Aload  output  1  load A
Sub  output  1  0: add, 1: subtract
halt  output  1  high in HALT state
state  output  4  current state encoding (debug)

Behaviour:
- Single clock domain: state register clocked by clk, cleared asynchronously by clear.
- While clear is high: state = FETCH and every output is 0.
- Outputs are combinational decodes of the state register (Moore). Exceptions, which are Mealy: PCload in JZ/JPOS and Aload in INPUT.
- State encodings: FETCH=0, LATCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10. Unused codes go to FETCH on the next edge.
- Any output not listed for a state below is 0 in that state.
- FETCH: all outputs 0, so the address is PC. Next state: LATCH.
- LATCH: IRload=1, PCload=1, JMPmux=0 (PC <- PC+1). Next state: DECODE.
- DECODE: Meminst=1, so the operand read starts at IR40. Dispatch on IR75:
  - 000 -> LOAD
  - 001 -> STORE
  - 010 -> ADD
  - 011 -> SUB
  - 100 -> INPUT
  - 101 -> JZ
  - 110 -> JPOS
  - 111 -> HALT
- LOAD: Meminst=1, Asel=ASEL_MEM, Aload=1. Next: FETCH.
- STORE: Meminst=1, MemWr=1. Next: FETCH.
- ADD: Meminst=1, Asel=ASEL_ALU, Sub=0, Aload=1. Next: FETCH.
- SUB: Meminst=1, Asel=ASEL_ALU, Sub=1, Aload=1. Next: FETCH.
- INPUT: Asel=ASEL_IN, Aload=enter.
  - Stays in INPUT while enter=0.
  - Goes to FETCH on the edge where enter=1.
  - Exactly one A load occurs per entry into INPUT, even if enter is held high.
- JZ: JMPmux=1, PCload=Aeq0. Next: FETCH.
- JPOS: JMPmux=1, PCload=Apos. Next: FETCH.
- Not-taken jump: PCload=0, so PC keeps the already-incremented value.
- HALT: halt=1, all strobes 0. Stays in HALT until clear.
- Instruction latency: 4 clocks for every opcode except INPUT (4 + enter wait) and HALT (terminal).
- MemWr and Aload are never asserted in the same cycle. IRload is asserted only in LATCH.
- Reset mid-instruction (e.g. clear in STORE): MemWr drops immediately (asynchronous). Execution restarts at FETCH after clear deasserts.

Optional Feature:
CU_STEP_EN
- Defined: FETCH holds until step=1 is sampled at a rising edge, then advances to LATCH. The remaining states run at full speed, so one instruction executes per step pulse.
- Not defined: step is ignored and FETCH always advances to LATCH. Timing matches the Behaviour section exactly.

Test Plan:
1. Reset and first fetch: assert clear mid-cycle -> all outputs 0 and state=0 immediately. After release, FETCH, LATCH (IRload=PCload=1, JMPmux=0), DECODE (Meminst=1) on consecutive edges.
2. Arithmetic sequence: IR75=000, then 010, then 011 -> LOAD asserts Asel=10/Aload; ADD asserts Asel=00/Sub=0/Aload; SUB asserts Sub=1. Each instruction returns to FETCH 4 clocks after its own FETCH.
3. Store: IR75=001 -> exactly one cycle with MemWr=1 and Meminst=1, Aload=0 throughout.
4. Conditional jumps:
   - IR75=101 with Aeq0=1 -> PCload=1, JMPmux=1 in JZ.
   - IR75=101 with Aeq0=0 -> PCload=0.
   - IR75=110 with Apos=1/0 -> PCload=1/0 respectively.
5. Input handshake: IR75=100, hold enter=0 for 5 clocks -> stays in INPUT (state=7), Aload=0. Raise enter -> one Aload pulse with Asel=01, then FETCH.
6. Halt and step:
   - IR75=111 -> halt=1 held for 20 clocks, no strobes. Clear -> FETCH.
   - With CU_STEP_EN: no LATCH until step=1.

Source files
------------

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: fetch/decode/execute sequencer for the 8-bit accumulator
// processor. Drives every datapath control strobe from the current state.
// Optional build macro CU_STEP_EN: FETCH waits for a step pulse before each
// instruction, so one instruction runs per pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | present PC to memory (all strobes low)
// LATCH   | load IR from memory data, PC <- PC+1
// DECODE  | present IR40 to memory, dispatch on IR75
// LOAD    | A <- mem[IR40]
// STORE   | mem[IR40] <- A
// ADD     | A <- A + mem[IR40]
// SUB     | A <- A - mem[IR40]
// INPUT   | wait for enter, then A <- input port (single load)
// JZ      | PC <- IR40 when A == 0
// JPOS    | PC <- IR40 when A > 0
// HALT    | stopped until clear
module control_unit_fsm #(
    parameter logic [1:0] ASEL_ALU = 2'b00,
    parameter logic [1:0] ASEL_IN  = 2'b01,
    parameter logic [1:0] ASEL_MEM = 2'b10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
    input  logic       step,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       halt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_LATCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t cur;

`ifdef CU_STEP_EN
    logic fetch_go;
    assign fetch_go = step;
`else
    logic fetch_go;
    logic unused_step;
    assign fetch_go    = 1'b1;
    assign unused_step = step;
`endif

    // State register: sequence through fetch/decode/execute, clear forces FETCH.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:  cur <= fetch_go ? S_LATCH : S_FETCH;
                S_LATCH:  cur <= S_DECODE;
                S_DECODE: begin
                    case (IR75)
                        3'b000:  cur <= S_LOAD;
                        3'b001:  cur <= S_STORE;
                        3'b010:  cur <= S_ADD;
                        3'b011:  cur <= S_SUB;
                        3'b100:  cur <= S_INPUT;
                        3'b101:  cur <= S_JZ;
                        3'b110:  cur <= S_JPOS;
                        default: cur <= S_HALT;
                    endcase
                end
                // Leaving INPUT on the same edge that enter is seen keeps the
                // A load to a single cycle even if enter stays high.
                S_INPUT:  cur <= enter ? S_FETCH : S_INPUT;
                S_HALT:   cur <= S_HALT;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // Output decode of the state; jump PCload and INPUT Aload follow live inputs.
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        halt    = 1'b0;
        case (cur)
            S_LATCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S_DECODE: Meminst = 1'b1;
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = ASEL_MEM;
                Aload   = 1'b1;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Asel    = ASEL_ALU;
                Aload   = 1'b1;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Asel    = ASEL_ALU;
                Sub     = 1'b1;
                Aload   = 1'b1;
            end
            S_INPUT: begin
                Asel  = ASEL_IN;
                Aload = enter;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

endmodule
